fbu_mem_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares the single-port FBU data/program RAM between requester 0 (FBCPU memory master) and requester 1 (program loader / debug master).
- Sits between the requesters and the RAM. Drives the RAM's MAR/MDRIn/RAMWr and samples MDROut.
- Each requester uses a valid/ready request channel and a one-cycle response pulse.

---
 rtl/fbu_mem_pkg.sv | 15 +
 rtl/fbu_rr_arb2.sv | 18 +
 rtl/fbu_mem_arbiter.sv | 109 ++++++++++
 tb/tb_fbu_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbu_mem_pkg.sv
// Shared widths, FSM encoding and port ids for the FBU RAM arbiter.
// Constants only; no logic, latency or backpressure of its own.
package fbu_mem_pkg;

    localparam int ADDRESS_WIDTH_DEF = 6;
    localparam int DATA_WIDTH_DEF    = 10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/fbu_rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
// Purely combinational, zero latency; a losing request simply stays pending.
module fbu_rr_arb2
    import fbu_mem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = (last_grant == PORT1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/fbu_mem_arbiter.sv
// Shares the single-port FBU RAM between the CPU (port 0) and the loader/debug master (port 1).
// Accept-to-response is 3 cycles, one access per 3 cycles; ready only in IDLE, losers wait.
module fbu_mem_arbiter
    import fbu_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic                     req0_we,
    input  logic [ADDRESS_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_wdata,
    output logic                     rsp0_valid,
    output logic [DATA_WIDTH-1:0]    rsp0_rdata,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic                     req1_we,
    input  logic [ADDRESS_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_wdata,
    output logic                     rsp1_valid,
    output logic [DATA_WIDTH-1:0]    rsp1_rdata,

    output logic [ADDRESS_WIDTH-1:0] ram_mar,
    output logic [DATA_WIDTH-1:0]    ram_mdr_in,
    output logic                     ram_wr,
    input  logic [DATA_WIDTH-1:0]    ram_mdr_out
);

    logic [1:0]               state;
    logic                     last_grant;
    logic [1:0]               grant;
    logic                     accept;
    logic                     lat_port;
    logic                     lat_we;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wdata;
    logic                     in_issue;

    fbu_rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0_ready = (state == ST_IDLE) && grant[0];
    assign req1_ready = (state == ST_IDLE) && grant[1];
    assign accept     = req0_ready || req1_ready;

    // RAM drive decodes straight from state so an async reset drops ram_wr at once.
    assign in_issue   = (state == ST_ISSUE);
    assign ram_mar    = in_issue ? lat_addr : '0;
    assign ram_wr     = in_issue && lat_we;
    assign ram_mdr_in = (in_issue && lat_we) ? lat_wdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= PORT1;
            lat_port   <= PORT0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_ISSUE;
                        lat_port   <= req1_ready ? PORT1 : PORT0;
                        last_grant <= req1_ready ? PORT1 : PORT0;
                        lat_we     <= req1_ready ? req1_we    : req0_we;
                        lat_addr   <= req1_ready ? req1_addr  : req0_addr;
                        lat_wdata  <= req1_ready ? req1_wdata : req0_wdata;
                    end
                end
                ST_ISSUE:   state <= ST_CAPTURE;
                ST_CAPTURE: state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // RAM read data is valid in CAPTURE; it is registered so the pulse lands one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
        end else begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            if (state == ST_CAPTURE) begin
                if (lat_port == PORT1) begin
                    rsp1_valid <= 1'b1;
                    rsp1_rdata <= lat_we ? '0 : ram_mdr_out;
                end else begin
                    rsp0_valid <= 1'b1;
                    rsp0_rdata <= lat_we ? '0 : ram_mdr_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_fbu_mem_arbiter.sv
// Bench for fbu_mem_arbiter: directed scenarios with literal expectations, then random traffic
// against a transaction-level model of the arbiter and the RAM it fronts.
module tb_fbu_mem_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic [AW-1:0] ram_mar;
    logic [DW-1:0] ram_mdr_in, ram_mdr_out;
    logic          ram_wr;

    fbu_mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_mar(ram_mar), .ram_mdr_in(ram_mdr_in), .ram_wr(ram_wr),
        .ram_mdr_out(ram_mdr_out)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM with a preload port used only while in reset.
    logic [DW-1:0] ram [DEPTH];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_dat;
    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_dat;
        else if (ram_wr) ram[ram_mar] <= ram_mdr_in;
        ram_mdr_out <= ram[ram_mar];
    end

    int checks = 0;
    int errors = 0;

    // Transaction model: m_phase counts cycles since acceptance (0 = free).
    logic [DW-1:0] mdl_mem [DEPTH];
    int            m_phase, m_last, m_port;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_rv  [2];
    logic [DW-1:0] m_rd  [2];
    logic          acc   [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner();
        if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_last = 1; m_port = 0;
        m_we = 1'b0; m_addr = '0; m_wdata = '0;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
    endtask

    task automatic model_compare();
        int w;
        w = winner();
        chk("req0_ready", 32'(req0_ready), 32'(m_phase == 0 && w == 0));
        chk("req1_ready", 32'(req1_ready), 32'(m_phase == 0 && w == 1));
        chk("ram_mar",    32'(ram_mar),    32'((m_phase == 1) ? m_addr : '0));
        chk("ram_wr",     32'(ram_wr),     32'(m_phase == 1 && m_we));
        chk("ram_mdr_in", 32'(ram_mdr_in), 32'((m_phase == 1 && m_we) ? m_wdata : '0));
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_rv[0]));
        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(m_rd[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_rv[1]));
        chk("rsp1_rdata", 32'(rsp1_rdata), 32'(m_rd[1]));
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_advance();
        int w;
        acc[0] = 1'b0; acc[1] = 1'b0;
        if (!rst) begin
            model_reset();
            return;
        end
        w = winner();
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        if (m_phase == 0) begin
            if (w >= 0) begin
                acc[w] = 1'b1; m_last = w; m_port = w; m_phase = 1;
                m_we    = (w == 0) ? req0_we    : req1_we;
                m_addr  = (w == 0) ? req0_addr  : req1_addr;
                m_wdata = (w == 0) ? req0_wdata : req1_wdata;
            end
        end else if (m_phase == 1) begin
            if (m_we) mdl_mem[m_addr] = m_wdata;
            m_phase = 2;
        end else begin
            m_rv[m_port] = 1'b1;
            m_rd[m_port] = m_we ? '0 : mdl_mem[m_addr];
            m_phase = 0;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_compare();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input logic accd, inout logic v, inout logic we,
                              inout logic [AW-1:0] a, inout logic [DW-1:0] d);
        logic fresh;
        fresh = 1'b0;
        if (v) begin
            if (accd) begin
                if ($urandom_range(0, 1) == 1) fresh = 1'b1;
                else v = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                v = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            fresh = 1'b1;
        end
        if (fresh) begin
            v  = 1'b1;
            we = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            d  = DW'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
        model_reset();
        acc[0] = 1'b0; acc[1] = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            pl_en   = 1'b1;
            pl_addr = AW'(i);
            pl_dat  = (i == 5) ? DW'(10'h2A) : DW'($urandom);
            mdl_mem[i] = pl_dat;
            @(posedge clk);
            #1;
        end
        pl_en = 1'b0;
        chk("reset_ram_wr",     32'(ram_wr),     32'(0));
        chk("reset_ram_mar",    32'(ram_mar),    32'(0));
        chk("reset_rsp0_valid", 32'(rsp0_valid), 32'(0));
        chk("reset_rsp1_rdata", 32'(rsp1_rdata), 32'(0));
        rst = 1'b1;

        // Port 0 reads RAM[5] = 0x2A.
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd5; req0_wdata = 10'h155;
        sample(); chk("t1_ready0", 32'(req0_ready), 32'(1)); tick();
        req0_valid = 1'b0;
        sample(); chk("t1_mar", 32'(ram_mar), 32'(5)); chk("t1_wr", 32'(ram_wr), 32'(0)); tick();
        sample(); tick();
        sample(); chk("t1_rsp0_valid", 32'(rsp0_valid), 32'(1));
        chk("t1_rsp0_rdata", 32'(rsp0_rdata), 32'(10'h2A)); tick();

        // Port 1 writes 0x3FF to 63; port 0 reads it back, accepted alongside the write response.
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 6'd63; req1_wdata = 10'h3FF;
        sample(); chk("t2_ready1", 32'(req1_ready), 32'(1)); tick();
        req1_valid = 1'b0;
        sample(); chk("t2_mar", 32'(ram_mar), 32'(63)); chk("t2_mdr_in", 32'(ram_mdr_in), 32'(10'h3FF));
        chk("t2_wr", 32'(ram_wr), 32'(1)); tick();
        sample(); chk("t2_wr_drop", 32'(ram_wr), 32'(0)); tick();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd63;
        sample(); chk("t2_rsp1_valid", 32'(rsp1_valid), 32'(1)); chk("t2_rsp1_rdata", 32'(rsp1_rdata), 32'(0));
        chk("t2_ready0_at_rsp", 32'(req0_ready), 32'(1)); tick();
        req0_valid = 1'b0;
        sample(); tick();
        sample(); tick();
        sample(); chk("t2_readback", 32'(rsp0_rdata), 32'(10'h3FF)); tick();

        // Both ports requesting continuously from reset: grants alternate 0,1,0,1.
        rst = 1'b0; #1; model_reset();
        sample(); tick();
        rst = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd1;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd2;
        for (int k = 0; k < 12; k++) begin
            sample();
            if (k % 3 == 0) begin
                chk("t3_grant0", 32'(req0_ready), 32'(((k / 3) % 2) == 0));
                chk("t3_grant1", 32'(req1_ready), 32'(((k / 3) % 2) == 1));
            end
            if (k == 4 || k == 5) chk("t3_ready0_busy", 32'(req0_ready), 32'(0));
            if (k == 3) chk("t3_rsp0_valid", 32'(rsp0_valid), 32'(1));
            if (k == 6) begin
                chk("t3_rsp1_valid", 32'(rsp1_valid), 32'(1));
                chk("t3_ready0_at_rsp1", 32'(req0_ready), 32'(1));
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during ISSUE of a write: abort, no response, port 0 wins the next tie.
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 6'd9; req0_wdata = 10'h155;
        sample(); chk("t5_ready0", 32'(req0_ready), 32'(1)); tick();
        req0_valid = 1'b0;
        sample(); chk("t5_wr_issue", 32'(ram_wr), 32'(1));
        rst = 1'b0; #1;
        chk("t5_wr_async", 32'(ram_wr), 32'(0));
        chk("t5_mar_async", 32'(ram_mar), 32'(0));
        model_reset();
        for (int k = 0; k < 3; k++) begin
            tick(); sample();
            chk("t5_no_rsp0", 32'(rsp0_valid), 32'(0));
        end
        rst = 1'b1; #1;
        chk("t5_post_mdr_in", 32'(ram_mdr_in), 32'(0));
        chk("t5_post_rdata0", 32'(rsp0_rdata), 32'(0));
        chk("t5_post_rdata1", 32'(rsp1_rdata), 32'(0));
        tick();
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 6'd9;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 6'd3;
        sample(); chk("t5_tie0", 32'(req0_ready), 32'(1)); chk("t5_tie1", 32'(req1_ready), 32'(0)); tick();

        for (int i = 0; i < 3000; i++) begin
            drive_port(acc[0], req0_valid, req0_we, req0_addr, req0_wdata);
            drive_port(acc[1], req1_valid, req1_we, req1_addr, req1_wdata);
            sample();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
